axi_burst_wr_master: RTL and testbench

Parametrised AXI4 write master that turns one user write request of arbitrary length into a sequence of legal INCR bursts. Each burst is capped at MAX_BURST beats and never crosses a BOUNDARY-byte address boundary. The block sits between the DDR2 controller's user-side traffic sources and the AXI write channels of the controller front end. It checks every write response and reports a sticky error at completion.

---
 rtl/axi_burst_wr_master.sv | 151 +++++++++++++++
 tb/tb_axi_burst_wr_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_wr_master.sv
// rtl/axi_burst_wr_master.sv - AXI4 write master splitting a request into capped, boundary-safe INCR bursts
module axi_burst_wr_master #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16,
  parameter int BOUNDARY   = 4096
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_trig,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [LEN_WIDTH-1:0]    wr_len,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_data_en,
  output logic                    wr_ready,
  output logic                    wr_done,
  output logic                    wr_err,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  input  logic [1:0]              axi_bresp
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BYTES - 1));

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, awaddr_q, awaddr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [8:0]              beats_q, beats_d;
  logic [7:0]              awlen_q, awlen_d, cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [31:0]             off, bnd_beats, lim;
  logic                    unused_bresp;

  assign unused_bresp = axi_bresp[0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      awaddr_q <= '0;
      rem_q    <= '0;
      beats_q  <= '0;
      awlen_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      awaddr_q <= awaddr_d;
      rem_q    <= rem_d;
      beats_q  <= beats_d;
      awlen_q  <= awlen_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    awaddr_d = awaddr_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    awlen_d  = awlen_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    // beats = min(remaining, MAX_BURST, beats left before the next boundary)
    off       = 32'(addr_q) & 32'(BOUNDARY - 1);
    bnd_beats = (32'(BOUNDARY) - off) >> SZ;
    lim       = 32'(rem_q);
    if (32'(MAX_BURST) < lim) lim = 32'(MAX_BURST);
    if (bnd_beats < lim) lim = bnd_beats;
    case (state_q)
      S_IDLE: begin
        if (wr_trig) begin
          err_d = 1'b0;
          if (wr_len != '0) begin
            addr_d  = wr_addr & ALIGN_MASK;
            rem_d   = wr_len;
            state_d = S_CALC;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CALC: begin
        beats_d  = 9'(lim);
        awaddr_d = addr_q;
        awlen_d  = 8'(lim - 32'd1);
        state_d  = S_AW;
      end
      S_AW: begin
        if (axi_awready) begin
          cnt_d   = awlen_q;
          state_d = S_W;
        end
      end
      S_W: begin
        if (axi_wready) begin
          if (cnt_q == 8'd0) state_d = S_B;
          else cnt_d = cnt_q - 8'd1;
        end
      end
      S_B: begin
        if (axi_bvalid) begin
          err_d   = err_q | axi_bresp[1];
          rem_d   = rem_q - LEN_WIDTH'(beats_q);
          addr_d  = addr_q + (ADDR_WIDTH'(beats_q) << SZ);
          state_d = (rem_q == LEN_WIDTH'(beats_q)) ? S_DONE : S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ready    = (state_q == S_IDLE);
    wr_done     = (state_q == S_DONE);
    axi_awvalid = (state_q == S_AW);
    axi_wvalid  = (state_q == S_W);
    axi_wlast   = (state_q == S_W) && (cnt_q == 8'd0);
    axi_bready  = (state_q == S_B);
    wr_data_en  = axi_wvalid & axi_wready;
  end

  assign wr_err      = err_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awsize  = 3'(SZ);
  assign axi_awburst = 2'b01;
  assign axi_wdata   = wr_data;
  assign axi_wstrb   = '1;

endmodule

// File: tb/tb_axi_burst_wr_master.sv
// tb/tb_axi_burst_wr_master.sv - table-driven bench for axi_burst_wr_master with a cycle-level AXI slave
module tb_axi_burst_wr_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_trig;
  logic [26:0] wr_addr;
  logic [15:0] wr_len;
  logic [15:0] wr_data;
  logic        wr_data_en, wr_ready, wr_done, wr_err;
  logic        axi_awvalid, axi_awready;
  logic [26:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_wvalid, axi_wready;
  logic [15:0] axi_wdata;
  logic [1:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;

  always #5 clk = ~clk;

  axi_burst_wr_master dut (
    .clk(clk), .rstn(rstn), .wr_trig(wr_trig), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_data(wr_data), .wr_data_en(wr_data_en), .wr_ready(wr_ready), .wr_done(wr_done),
    .wr_err(wr_err), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
  );

  typedef struct {
    logic [26:0]       addr;
    logic [15:0]       len;
    int                awdly;
    bit                wtog;
    int                errb;
    int                nb;
    logic [2:0][26:0]  ea;
    logic [2:0][7:0]   el;
    bit                experr;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];
  int n_app  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_app++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [26:0] a, input logic [15:0] l, input int dly,
                              input bit tg, input int eb, input int nb,
                              input logic [26:0] a0, input logic [7:0] l0,
                              input logic [26:0] a1, input logic [7:0] l1,
                              input logic [26:0] a2, input logic [7:0] l2, input bit ee);
    vec_t v;
    v.addr = a; v.len = l; v.awdly = dly; v.wtog = tg; v.errb = eb; v.nb = nb;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2;
    v.el[0] = l0; v.el[1] = l1; v.el[2] = l2;
    v.experr = ee;
    return v;
  endfunction

  task automatic run_vec(input int vi);
    vec_t v;
    logic [26:0] rec_a[$];
    logic [7:0]  rec_l[$];
    logic [26:0] p_addr;
    logic [7:0]  p_len;
    logic        prev_awv, prev_awr, prev_wv, prev_wr, prev_br, tog, err_at_done;
    int aw_wait, beats, inb, wl, wl_err, done, stab, tim, derr, cur_len;
    int last_aw_k, last_w_k, last_b, bi;
    bit finished;
    v = vecs[vi];
    prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0; prev_br = 0; tog = 0;
    err_at_done = 0; p_addr = '0; p_len = '0;
    aw_wait = 0; beats = 0; inb = 0; wl = 0; wl_err = 0; done = 0; stab = 0; tim = 0;
    derr = 0; cur_len = 0; last_aw_k = -10; last_w_k = -10; last_b = -10; finished = 0;
    @(negedge clk);
    check($sformatf("v%0d ready_before", vi), 64'(wr_ready), 64'(1));
    wr_addr = v.addr; wr_len = v.len; wr_trig = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (k > 0) begin
        wr_addr = 27'($urandom);
        wr_len  = 16'($urandom);
      end
      if (wr_done) wr_trig = 1'b0;
      if (axi_awvalid) begin
        axi_awready = (aw_wait >= v.awdly);
        aw_wait++;
      end else begin
        axi_awready = 1'b0;
        aw_wait = 0;
      end
      tog = ~tog;
      axi_wready = v.wtog ? tog : 1'b1;
      axi_bvalid = axi_bready;
      bi = rec_a.size() - 1;
      axi_bresp  = axi_bvalid ? ((bi == v.errb) ? 2'b10 : 2'b00) : 2'b11;
      wr_data = 16'($urandom);
      #1;
      if (axi_awvalid && !prev_awv) begin
        if (rec_a.size() == 0) begin
          if (k != 2) tim++;
        end else if (k != last_b + 2) tim++;
      end
      if (axi_wvalid && !prev_wv && k != last_aw_k + 1) tim++;
      if (axi_bready && !prev_br && k != last_w_k + 1) tim++;
      if (prev_awv && !prev_awr && (!axi_awvalid || axi_awaddr !== p_addr || axi_awlen !== p_len)) stab++;
      if (prev_wv && !prev_wr && !axi_wvalid) stab++;
      if (axi_awvalid && axi_awready) begin
        rec_a.push_back(axi_awaddr);
        rec_l.push_back(axi_awlen);
        cur_len = int'(axi_awlen);
        last_aw_k = k;
      end
      if (wr_data_en !== (axi_wvalid & axi_wready)) derr++;
      if (axi_wvalid && axi_wready) begin
        beats++;
        inb++;
        if (axi_wdata !== wr_data) derr++;
        if (axi_wlast) begin
          wl++;
          if (inb != cur_len + 1) wl_err++;
          inb = 0;
          last_w_k = k;
        end
      end
      if (axi_bvalid && axi_bready) last_b = k;
      if (wr_done) begin
        done++;
        err_at_done = wr_err;
        if (k != last_b + 1) tim++;
      end
      prev_awv = axi_awvalid; prev_awr = axi_awready; p_addr = axi_awaddr; p_len = axi_awlen;
      prev_wv = axi_wvalid; prev_wr = axi_wready; prev_br = axi_bready;
      if (wr_done) begin
        finished = 1;
        break;
      end
      @(negedge clk);
    end
    wr_trig = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    check($sformatf("v%0d completed_in_budget", vi), 64'(finished), 64'(1));
    check($sformatf("v%0d nbursts", vi), 64'(rec_a.size()), 64'(v.nb));
    for (int i = 0; i < v.nb; i++) begin
      check($sformatf("v%0d awaddr[%0d]", vi, i), (i < rec_a.size()) ? 64'(rec_a[i]) : '1, 64'(v.ea[i]));
      check($sformatf("v%0d awlen[%0d]", vi, i), (i < rec_l.size()) ? 64'(rec_l[i]) : '1, 64'(v.el[i]));
    end
    check($sformatf("v%0d beats", vi), 64'(beats), 64'(v.len));
    check($sformatf("v%0d wlast_count", vi), 64'(wl), 64'(v.nb));
    check($sformatf("v%0d wlast_position", vi), 64'(wl_err), 64'(0));
    check($sformatf("v%0d done_count", vi), 64'(done), 64'(1));
    check($sformatf("v%0d err_at_done", vi), 64'(err_at_done), 64'(v.experr));
    check($sformatf("v%0d valid_stability", vi), 64'(stab), 64'(0));
    check($sformatf("v%0d handshake_timing", vi), 64'(tim), 64'(0));
    check($sformatf("v%0d data_path", vi), 64'(derr), 64'(0));
    @(negedge clk);
    check($sformatf("v%0d ready_after", vi), 64'(wr_ready), 64'(1));
    check($sformatf("v%0d done_pulse_width", vi), 64'(wr_done), 64'(0));
    check($sformatf("v%0d err_held", vi), 64'(wr_err), 64'(v.experr));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctrl_outputs"},
          64'({wr_ready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready, wr_done, wr_err, wr_data_en}),
          64'(8'b1000_0000));
    check({tag, " awaddr"}, 64'(axi_awaddr), 64'(0));
    check({tag, " awlen"}, 64'(axi_awlen), 64'(0));
  endtask

  initial begin
    int budget;
    vecs[0] = mk(27'h0,   16'd8,  0, 0, -1, 1, 27'h0,   8'd7,  27'h0,    8'd0, 27'h0,  8'd0, 0);
    vecs[1] = mk(27'h0,   16'd40, 0, 0, -1, 3, 27'h0,   8'd15, 27'h20,   8'd15, 27'h40, 8'd7, 0);
    vecs[2] = mk(27'hFF8, 16'd10, 0, 0, -1, 2, 27'hFF8, 8'd3,  27'h1000, 8'd5, 27'h0,  8'd0, 0);
    vecs[3] = mk(27'h0,   16'd40, 3, 1, -1, 3, 27'h0,   8'd15, 27'h20,   8'd15, 27'h40, 8'd7, 0);
    vecs[4] = mk(27'h0,   16'd40, 0, 0,  1, 3, 27'h0,   8'd15, 27'h20,   8'd15, 27'h40, 8'd7, 1);
    vecs[5] = mk(27'h0,   16'd8,  0, 0, -1, 1, 27'h0,   8'd7,  27'h0,    8'd0, 27'h0,  8'd0, 0);
    vecs[6] = mk(27'h3,   16'd3,  1, 1, -1, 1, 27'h2,   8'd2,  27'h0,    8'd0, 27'h0,  8'd0, 0);
    vecs[7] = mk(27'hFE0, 16'd20, 0, 1, -1, 2, 27'hFE0, 8'd15, 27'h1000, 8'd3, 27'h0,  8'd0, 0);
    vecs[8] = mk(27'h100, 16'd17, 2, 0,  0, 2, 27'h100, 8'd15, 27'h120,  8'd0, 27'h0,  8'd0, 1);

    rstn = 1'b0; wr_trig = 1'b0; wr_addr = '0; wr_len = '0; wr_data = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("consts", 64'({axi_awsize, axi_awburst, axi_wstrb}), 64'({3'd1, 2'b01, 2'b11}));
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    for (int i = 0; i < NV; i++) run_vec(i);

    // empty request after an errored one: wr_err clears, done at T+1, ready at T+2
    check("err_sticky_idle", 64'(wr_err), 64'(1));
    wr_addr = 27'h40; wr_len = 16'd0; wr_trig = 1'b1;
    @(negedge clk);
    wr_trig = 1'b0;
    check("len0 T+1", 64'({wr_done, axi_awvalid, wr_ready, wr_err}), 64'(4'b1000));
    @(negedge clk);
    check("len0 T+2", 64'({wr_done, axi_awvalid, wr_ready}), 64'(3'b001));

    // reset while stalled in W
    wr_addr = 27'h0; wr_len = 16'd8; wr_trig = 1'b1;
    @(negedge clk);
    wr_trig = 1'b0; axi_awready = 1'b1; axi_wready = 1'b0;
    budget = 0;
    while (!axi_wvalid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("rst_reached_w", 64'(axi_wvalid), 64'(1));
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_in_w");
    rstn = 1'b1; axi_awready = 1'b0;
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_fail);
    $finish;
  end

endmodule
